// File: rtl/instr_pkg.sv
// instr_pkg: op/format enumerations and the RV32I encoding table shared by instr_encode and instr_decode.
package instr_pkg;

    localparam int ENC_FIFO_DEPTH = 2;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
    } ctrl_t;

    function automatic ctrl_t op_lookup(logic [5:0] op);
        ctrl_t c;
        c = '{FMT_BAD, 7'd0, 3'd0, 7'd0};
        case (op)
            OP_LUI:   c = '{FMT_U, OPC_LUI, 3'd0, 7'd0};
            OP_AUIPC: c = '{FMT_U, OPC_AUIPC, 3'd0, 7'd0};
            OP_JAL:   c = '{FMT_J, OPC_JAL, 3'd0, 7'd0};
            OP_JALR:  c = '{FMT_I, OPC_JALR, 3'd0, 7'd0};
            OP_BEQ:   c = '{FMT_B, OPC_BRANCH, 3'd0, 7'd0};
            OP_BNE:   c = '{FMT_B, OPC_BRANCH, 3'd1, 7'd0};
            OP_BLT:   c = '{FMT_B, OPC_BRANCH, 3'd4, 7'd0};
            OP_BGE:   c = '{FMT_B, OPC_BRANCH, 3'd5, 7'd0};
            OP_BLTU:  c = '{FMT_B, OPC_BRANCH, 3'd6, 7'd0};
            OP_BGEU:  c = '{FMT_B, OPC_BRANCH, 3'd7, 7'd0};
            OP_LB:    c = '{FMT_I, OPC_LOAD, 3'd0, 7'd0};
            OP_LH:    c = '{FMT_I, OPC_LOAD, 3'd1, 7'd0};
            OP_LW:    c = '{FMT_I, OPC_LOAD, 3'd2, 7'd0};
            OP_LBU:   c = '{FMT_I, OPC_LOAD, 3'd4, 7'd0};
            OP_LHU:   c = '{FMT_I, OPC_LOAD, 3'd5, 7'd0};
            OP_SB:    c = '{FMT_S, OPC_STORE, 3'd0, 7'd0};
            OP_SH:    c = '{FMT_S, OPC_STORE, 3'd1, 7'd0};
            OP_SW:    c = '{FMT_S, OPC_STORE, 3'd2, 7'd0};
            OP_ADDI:  c = '{FMT_I, OPC_OP_IMM, 3'd0, 7'd0};
            OP_SLTI:  c = '{FMT_I, OPC_OP_IMM, 3'd2, 7'd0};
            OP_SLTIU: c = '{FMT_I, OPC_OP_IMM, 3'd3, 7'd0};
            OP_XORI:  c = '{FMT_I, OPC_OP_IMM, 3'd4, 7'd0};
            OP_ORI:   c = '{FMT_I, OPC_OP_IMM, 3'd6, 7'd0};
            OP_ANDI:  c = '{FMT_I, OPC_OP_IMM, 3'd7, 7'd0};
            OP_SLLI:  c = '{FMT_I, OPC_OP_IMM, 3'd1, 7'd0};
            OP_SRLI:  c = '{FMT_I, OPC_OP_IMM, 3'd5, 7'd0};
            OP_SRAI:  c = '{FMT_I, OPC_OP_IMM, 3'd5, F7_ALT};
            OP_ADD:   c = '{FMT_R, OPC_OP, 3'd0, 7'd0};
            OP_SUB:   c = '{FMT_R, OPC_OP, 3'd0, F7_ALT};
            OP_SLL:   c = '{FMT_R, OPC_OP, 3'd1, 7'd0};
            OP_SLT:   c = '{FMT_R, OPC_OP, 3'd2, 7'd0};
            OP_SLTU:  c = '{FMT_R, OPC_OP, 3'd3, 7'd0};
            OP_XOR:   c = '{FMT_R, OPC_OP, 3'd4, 7'd0};
            OP_SRL:   c = '{FMT_R, OPC_OP, 3'd5, 7'd0};
            OP_SRA:   c = '{FMT_R, OPC_OP, 3'd5, F7_ALT};
            OP_OR:    c = '{FMT_R, OPC_OP, 3'd6, 7'd0};
            OP_AND:   c = '{FMT_R, OPC_OP, 3'd7, 7'd0};
            default:  c = '{FMT_BAD, 7'd0, 3'd0, 7'd0};
        endcase
        return c;
    endfunction

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(logic [31:0] v, int unsigned bits);
        logic [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encode_if.sv
// instr_encode_if: field-bundle input handshake and encoded-word output handshake.
// master drives the bundle and out_ready; slave (the encoder) drives in_ready, out_valid, instr, err.
interface instr_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    modport master (
        output in_valid, op, rs1, rs2, rd, imm, out_ready,
        input  in_ready, out_valid, instr, err
    );
    modport slave (
        input  in_valid, op, rs1, rs2, rd, imm, out_ready,
        output in_ready, out_valid, instr, err
    );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer.
// Ports: op_i/rs1_i/rs2_i/rd_i/imm_i fields in; instr_o machine word, err_o unencodable flag out.
// Build option INSTR_ENCODE_RANGE_CHECK_EN: flag immediates that do not fit the format.
module instr_pack
    import instr_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);
    ctrl_t       c;
    logic [11:0] imm_lo;
    logic        rng_err;

    assign c = op_lookup(op_i);
    // Immediate shifts keep funct7 in imm[11:5] with only the shamt from the operand.
    assign imm_lo = (c.opcode == OPC_OP_IMM && c.f3[1:0] == 2'b01) ? {c.f7, imm_i[4:0]} : imm_i[11:0];

    always_comb begin
        case (c.fmt)
            FMT_R:   instr_o = {c.f7, rs2_i, rs1_i, c.f3, rd_i, c.opcode};
            FMT_I:   instr_o = {imm_lo, rs1_i, c.f3, rd_i, c.opcode};
            FMT_S:   instr_o = {imm_i[11:5], rs2_i, rs1_i, c.f3, imm_i[4:0], c.opcode};
            FMT_B:   instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, c.f3, imm_i[4:1], imm_i[11], c.opcode};
            FMT_U:   instr_o = {imm_i[31:12], rd_i, c.opcode};
            FMT_J:   instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, c.opcode};
            default: instr_o = '0;
        endcase
    end

`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    always_comb begin
        case (c.fmt)
            FMT_I, FMT_S: rng_err = !fits_signed(imm_i, 12);
            FMT_B:        rng_err = !fits_signed(imm_i, 13) || imm_i[0];
            FMT_J:        rng_err = !fits_signed(imm_i, 21) || imm_i[0];
            FMT_U:        rng_err = imm_i[11:0] != '0;
            default:      rng_err = 1'b0;
        endcase
    end
`else
    assign rng_err = 1'b0;
`endif

    assign err_o = (c.fmt == FMT_BAD) || rng_err;

endmodule

// File: rtl/instr_encode.sv
// instr_encode: RV32I instruction encoder with a 2-entry output FIFO of {err, instr}.
// Ports: clk, rst (async, active-high); bus (instr_encode_if.slave) carries both handshakes.
// Build option INSTR_ENCODE_RANGE_CHECK_EN: forwarded to instr_pack for immediate range errors.
module instr_encode
    import instr_pkg::*;
(
    input logic           clk,
    input logic           rst,
    instr_encode_if.slave bus
);
    logic [32:0] mem_q [ENC_FIFO_DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic        rdy_q;
    logic        push;
    logic        pop;
    logic [31:0] enc_instr;
    logic        enc_err;

    instr_pack u_pack (
        .op_i    (bus.op),
        .rs1_i   (bus.rs1),
        .rs2_i   (bus.rs2),
        .rd_i    (bus.rd),
        .imm_i   (bus.imm),
        .instr_o (enc_instr),
        .err_o   (enc_err)
    );

    assign push  = bus.in_valid && rdy_q;
    assign pop   = bus.out_valid && bus.out_ready;
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    // in_ready is a register of next-cycle not-full, so it is low throughout reset
    // and never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= {enc_err, enc_instr};
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            cnt_q    <= cnt_d;
            rdy_q    <= cnt_d != 2'(ENC_FIFO_DEPTH);
        end
    end

    assign bus.in_ready           = rdy_q;
    assign bus.out_valid          = cnt_q != 2'd0;
    assign {bus.err, bus.instr}   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: directed-vector bench for instr_encode.
module tb_instr_encode;
    import instr_pkg::*;

`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    instr_encode_if bus_if ();

    instr_encode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(logic [5:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] imm);
        bus_if.op  = op;
        bus_if.rs1 = rs1;
        bus_if.rs2 = rs2;
        bus_if.rd  = rd;
        bus_if.imm = imm;
    endtask

    task automatic single(string tag, logic [5:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          logic [31:0] imm, logic [31:0] exp_instr, logic exp_err);
        drive(op, rs1, rs2, rd, imm);
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        check({tag, ".valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, ".instr"}, bus_if.instr, exp_instr);
        check({tag, ".err"}, 32'(bus_if.err), 32'(exp_err));
        tick();
        check({tag, ".drain"}, 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();
        check("rst.in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst.instr", bus_if.instr, 32'd0);
        check("rst.err", 32'(bus_if.err), 32'd0);
        rst = 1'b0;
        #1;
        check("rel.in_ready_pre", 32'(bus_if.in_ready), 32'd0);
        tick();
        check("rel.in_ready", 32'(bus_if.in_ready), 32'd1);

        single("addi", OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd1000, 32'h3E808093, 1'b0);
        single("beq", OP_BEQ, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463, 1'b0);
        single("addi4096", OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd4096, 32'h00008093, RC);
        single("badop", 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'h00000000, 1'b1);
        single("lui", OP_LUI, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
        single("sw", OP_SW, 5'd2, 5'd3, 5'd0, 32'hFFFFFFFC, 32'hFE312E23, 1'b0);
        single("sub", OP_SUB, 5'd1, 5'd2, 5'd3, 32'd0, 32'h402081B3, 1'b0);
        single("jal", OP_JAL, 5'd0, 5'd0, 5'd1, 32'd16, 32'h010000EF, 1'b0);
        single("srai", OP_SRAI, 5'd1, 5'd0, 5'd1, 32'd3, 32'h4030D093, 1'b0);

        bus_if.out_ready = 1'b0;
        drive(OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd1);
        bus_if.in_valid = 1'b1;
        tick();
        check("bp.rdy1", 32'(bus_if.in_ready), 32'd1);
        check("bp.val1", 32'(bus_if.out_valid), 32'd1);
        check("bp.a1", bus_if.instr, 32'h00108093);
        drive(OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd2);
        tick();
        check("bp.rdy2", 32'(bus_if.in_ready), 32'd0);
        check("bp.a2", bus_if.instr, 32'h00108093);
        drive(OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd3);
        tick();
        check("bp.rdy3", 32'(bus_if.in_ready), 32'd0);
        check("bp.hold", bus_if.instr, 32'h00108093);
        check("bp.val3", 32'(bus_if.out_valid), 32'd1);
        bus_if.out_ready = 1'b1;
        tick();
        check("bp.b", bus_if.instr, 32'h00208093);
        check("bp.rdy4", 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        check("bp.c", bus_if.instr, 32'h00308093);
        check("bp.val5", 32'(bus_if.out_valid), 32'd1);
        tick();
        check("bp.empty", 32'(bus_if.out_valid), 32'd0);

        bus_if.out_ready = 1'b0;
        drive(OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd7);
        bus_if.in_valid = 1'b1;
        tick();
        tick();
        bus_if.in_valid = 1'b0;
        check("full.rdy", 32'(bus_if.in_ready), 32'd0);
        check("full.val", 32'(bus_if.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.val", 32'(bus_if.out_valid), 32'd0);
        check("mid.rdy", 32'(bus_if.in_ready), 32'd0);
        check("mid.instr", bus_if.instr, 32'd0);
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check("post.rdy", 32'(bus_if.in_ready), 32'd1);
        check("post.val", 32'(bus_if.out_valid), 32'd0);
        single("post", OP_ADDI, 5'd1, 5'd0, 5'd1, 32'd1000, 32'h3E808093, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
